modport_fifo: RTL and testbench



---
 rtl/modport_fifo.sv | 136 +++++++++++++
 tb/tb_modport_fifo.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/modport_fifo.sv
// ----------------------------------------------------------------------------
// modport_fifo
//   Single-clock synchronous FIFO between a producer (write side) and a
//   consumer (read side). Words come out in the order they were written.
//   The read data is registered: a word appears on data_out in the cycle
//   after its read strobe is sampled. full and empty come straight from the
//   registered occupancy count.
//
//   Optional build macro FIFO_ERR_FLAGS_EN adds the overflow and underflow
//   outputs. Each is a one-cycle registered pulse that flags a write refused
//   while full or a read refused while empty. Without the macro those ports
//   and their logic are absent, and the core behaviour is unchanged.
//
//   DEPTH must be a power of two and at least 2, so that the pointers wrap
//   through their natural binary rollover.
// ----------------------------------------------------------------------------
module modport_fifo #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 16
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  write,
   input  logic                  read,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  full,
   output logic                  empty
`ifdef FIFO_ERR_FLAGS_EN
   ,
   output logic                  overflow,
   output logic                  underflow
`endif
);

   // Pointer width is derived from DEPTH and cannot be overridden.
   localparam int ADDR_WIDTH = $clog2(DEPTH);
   localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH+1)'(DEPTH);

   // Storage array. It is never reset, because a reset discards the contents
   // through the pointers and the count.
   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_WIDTH:0]   count_q,  count_d;
   logic [DATA_WIDTH-1:0] data_out_q, data_out_d;

   logic full_w;
   logic empty_w;
   logic wr_en;
   logic rd_en;

   // Status flags and the accept decisions, all taken from the registered count.
   always_comb begin
      full_w  = (count_q == DEPTH_CNT);
      empty_w = (count_q == '0);
      wr_en   = write && !full_w;
      rd_en   = read  && !empty_w;
   end

   // Next state of the pointers, the count and the registered read data.
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      data_out_d = data_out_q;

      if (wr_en) begin
         wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
      end

      if (rd_en) begin
         rd_ptr_d   = rd_ptr_q + ADDR_WIDTH'(1);
         data_out_d = mem_q[rd_ptr_q];
      end

      case ({wr_en, rd_en})
         2'b10:   count_d = count_q + (ADDR_WIDTH+1)'(1);
         2'b01:   count_d = count_q - (ADDR_WIDTH+1)'(1);
         default: count_d = count_q;
      endcase
   end

   // Control and output registers, cleared immediately by the async reset.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         data_out_q <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         data_out_q <= data_out_d;
      end
   end

   // Memory write port. A word written here is not readable until the next cycle.
   always_ff @(posedge clock) begin
      if (wr_en) begin
         mem_q[wr_ptr_q] <= data_in;
      end
   end

   assign data_out = data_out_q;
   assign full     = full_w;
   assign empty    = empty_w;

`ifdef FIFO_ERR_FLAGS_EN
   logic overflow_q,  overflow_d;
   logic underflow_q, underflow_d;

   // Flag requests that the current status will refuse.
   always_comb begin
      overflow_d  = write && full_w;
      underflow_d = read  && empty_w;
   end

   // Register the refused-request flags as one-cycle pulses.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   assign overflow  = overflow_q;
   assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_modport_fifo.sv
// ----------------------------------------------------------------------------
// tb_modport_fifo
//   Self-checking bench for modport_fifo. A queue-based reference model
//   decides what is accepted and what each read returns. Directed sequences
//   run first, followed by randomized traffic. Build with FIFO_ERR_FLAGS_EN
//   defined to also check the overflow and underflow pulses.
// ----------------------------------------------------------------------------
module tb_modport_fifo;

   localparam int DW    = 8;
   localparam int DEPTH = 16;

   logic          clock = 1'b0;
   logic          reset;
   logic [DW-1:0] data_in;
   logic          write;
   logic          read;
   logic [DW-1:0] data_out;
   logic          full;
   logic          empty;
`ifdef FIFO_ERR_FLAGS_EN
   logic          overflow;
   logic          underflow;
`endif

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state.
   logic [DW-1:0] model_q [$];
   logic [DW-1:0] exp_dout;
   logic          exp_ovf;
   logic          exp_udf;

   always #5 clock = ~clock;

   modport_fifo #(
      .DATA_WIDTH (DW),
      .DEPTH      (DEPTH)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .data_in   (data_in),
      .write     (write),
      .read      (read),
      .data_out  (data_out),
      .full      (full),
      .empty     (empty)
`ifdef FIFO_ERR_FLAGS_EN
      ,
      .overflow  (overflow),
      .underflow (underflow)
`endif
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic check_outputs(input string tag);
      check({tag, ":data_out"}, 32'(data_out), 32'(exp_dout));
      check({tag, ":full"},     32'(full),     32'(model_q.size() == DEPTH));
      check({tag, ":empty"},    32'(empty),    32'(model_q.size() == 0));
`ifdef FIFO_ERR_FLAGS_EN
      check({tag, ":overflow"},  32'(overflow),  32'(exp_ovf));
      check({tag, ":underflow"}, 32'(underflow), 32'(exp_udf));
`endif
   endtask

   // Called at a negedge. Drives one cycle of strobes, advances the model over
   // the posedge, then checks the DUT at the following negedge.
   task automatic step(input logic w, input logic r, input logic [DW-1:0] d, input string tag);
      bit was_full;
      bit was_empty;
      write   = w;
      read    = r;
      data_in = d;
      @(posedge clock);
      was_full  = (model_q.size() == DEPTH);
      was_empty = (model_q.size() == 0);
      exp_ovf   = w && was_full;
      exp_udf   = r && was_empty;
      if (r && !was_empty) exp_dout = model_q.pop_front();
      if (w && !was_full)  model_q.push_back(d);
      @(negedge clock);
      check_outputs(tag);
   endtask

   task automatic model_reset();
      model_q.delete();
      exp_dout = '0;
      exp_ovf  = 1'b0;
      exp_udf  = 1'b0;
   endtask

   // Asserts reset partway through a low clock phase, checks that the outputs
   // clear before any clock edge, then releases reset at a later negedge.
   task automatic async_reset(input string tag);
      #2;
      reset = 1'b1;
      write = 1'b0;
      read  = 1'b0;
      #1;
      model_reset();
      check_outputs(tag);
      @(negedge clock);
      reset = 1'b0;
   endtask

   task automatic drain(input string tag);
      for (int i = 0; i < 2 * DEPTH && model_q.size() > 0; i++) step(1'b0, 1'b1, '0, tag);
   endtask

   initial begin
      reset   = 1'b1;
      write   = 1'b0;
      read    = 1'b0;
      data_in = '0;
      model_reset();

      // Reset, then idle.
      @(negedge clock);
      check_outputs("reset");
      reset = 1'b0;
      step(1'b0, 1'b0, 8'h00, "idle");

      // Three writes, then three reads.
      step(1'b1, 1'b0, 8'h11, "wr3");
      step(1'b1, 1'b0, 8'h22, "wr3");
      step(1'b1, 1'b0, 8'h33, "wr3");
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'h00, "rd3");
      check("rd3:last", 32'(data_out), 32'h33);

      // Fill to full, make one ignored write, then drain.
      for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, DW'(i), "fill");
      check("fill:full", 32'(full), 32'd1);
      step(1'b1, 1'b0, 8'hAA, "wr_full");
      for (int i = 0; i < DEPTH; i++) begin
         step(1'b0, 1'b1, 8'h00, "drain16");
         check("drain16:order", 32'(data_out), 32'(i));
      end

      // Read while empty: data_out holds 0x0F.
      step(1'b0, 1'b1, 8'h00, "rd_empty");
      check("rd_empty:hold", 32'(data_out), 32'h0F);
      step(1'b0, 1'b0, 8'h00, "rd_empty_after");

      // Simultaneous read and write while empty.
      step(1'b1, 1'b1, 8'h5A, "rw_empty");
      check("rw_empty:hold", 32'(data_out), 32'h0F);
      check("rw_empty:empty", 32'(empty), 32'd0);
      drain("rw_empty_drain");

      // Simultaneous read and write with 5 words stored.
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'hC0 + DW'(i), "fill5");
      step(1'b1, 1'b1, 8'h77, "rw_mid");
      check("rw_mid:count", 32'(model_q.size()), 32'd5);
      drain("rw_mid_drain");

      // Simultaneous read and write while full.
      for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 8'h80 + DW'(i), "fill_rw");
      step(1'b1, 1'b1, 8'hEE, "rw_full");
      check("rw_full:full", 32'(full), 32'd0);
      check("rw_full:dout", 32'(data_out), 32'h80);
      drain("rw_full_drain");

      // 40 words, interleaved, so the pointers wrap.
      for (int i = 0; i < 40; i++) step(1'b1, (i % 3) != 0, 8'h40 + DW'(i), "wrap");
      drain("wrap_drain");

      // Reset in the middle of traffic.
      for (int i = 0; i < 6; i++) step(1'b1, 1'b0, DW'($urandom), "pre_rst");
      async_reset("mid_reset");
      step(1'b0, 1'b0, 8'h00, "post_rst");

      // Randomized traffic, with phases biased toward filling and toward draining.
      for (int ph = 0; ph < 8; ph++) begin
         int wp;
         int rp;
         wp = (ph % 2 == 0) ? 80 : 25;
         rp = (ph % 2 == 0) ? 25 : 80;
         for (int i = 0; i < 60; i++) begin
            step($urandom_range(99) < wp, $urandom_range(99) < rp, DW'($urandom), "rand");
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
